// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: shares a bank of N set/reset cells between requesters A and B.
// Each cycle it grants at most one single-cell set/clear command (round-robin
// on contention) or advances a clear-all sweep. s_vec/r_vec are registered
// one-hot drives that never overlap. flags mirrors the bank contents.
// Optional build macro SR_CTRL_STATS_EN enables the 8-bit contention counter
// on contend_cnt. Without it, contend_cnt is tied to zero.
//
// Handshake: a requester raises req with op/idx and holds all three stable
// until ack. ack is a one-cycle pulse in the cycle after the grant edge. req
// is ignored while that requester's ack is high, so a requester that keeps
// req asserted issues at most one command every two cycles.
module sr_bank_ctrl #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             op_a,
    input  logic [IDX_W-1:0] idx_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic             op_b,
    input  logic [IDX_W-1:0] idx_b,
    output logic             ack_b,
    input  logic             clr_all,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [N-1:0]     s_vec,
    output logic [N-1:0]     r_vec,
    output logic [N-1:0]     flags,
    output logic [7:0]       contend_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    localparam logic [N-1:0]     ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   N_LIM    = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_b;      // 1: the last contended grant went to B
    logic [IDX_W-1:0] r_sweep_idx;

    logic             w_elig_a;
    logic             w_elig_b;
    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_contend;
    logic             w_start_sweep;
    logic             w_sweep_step;
    logic             w_sweep_last;
    logic             w_g_valid;
    logic             w_g_op;
    logic [IDX_W-1:0] w_g_idx;
    logic             w_g_in_range;
    logic [N-1:0]     w_g_onehot;
    logic [N-1:0]     w_sweep_onehot;

    // A requester is not eligible in the cycle its own ack is showing.
    assign w_elig_a  = req_a & ~ack_a;
    assign w_elig_b  = req_b & ~ack_b;
    assign w_contend = w_elig_a & w_elig_b;

    assign w_g_valid      = w_gnt_a | w_gnt_b;
    assign w_g_op         = w_gnt_a ? op_a : op_b;
    assign w_g_idx        = w_gnt_a ? idx_a : idx_b;
    assign w_g_in_range   = ({1'b0, w_g_idx} < N_LIM);
    assign w_g_onehot     = ONE << w_g_idx;
    assign w_sweep_onehot = ONE << r_sweep_idx;

    assign busy = (r_state == ST_SWEEP);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, arbitration and sweep control; clr_all outranks requests.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_a       = 1'b0;
        w_gnt_b       = 1'b0;
        w_start_sweep = 1'b0;
        w_sweep_step  = 1'b0;
        w_sweep_last  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_all) begin
                    w_state_nxt   = ST_SWEEP;
                    w_start_sweep = 1'b1;
                end else if (w_contend) begin
                    w_gnt_a = r_last_b;
                    w_gnt_b = ~r_last_b;
                end else begin
                    w_gnt_a = w_elig_a;
                    w_gnt_b = w_elig_b;
                end
            end
            ST_SWEEP: begin
                w_sweep_step = 1'b1;
                if (r_sweep_idx == LAST_IDX) begin
                    w_sweep_last = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered bank drive, flag mirror, acks and pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_vec       <= '0;
            r_vec       <= '0;
            flags       <= '0;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            err         <= 1'b0;
            done        <= 1'b0;
            r_last_b    <= 1'b1;
            r_sweep_idx <= '0;
        end else begin
            s_vec <= '0;
            r_vec <= '0;
            ack_a <= w_gnt_a;
            ack_b <= w_gnt_b;
            err   <= w_g_valid & ~w_g_in_range;
            done  <= w_sweep_last;
            if (w_contend && (r_state == ST_IDLE) && !clr_all) begin
                r_last_b <= w_gnt_b;
            end
            if (w_g_valid && w_g_in_range) begin
                if (w_g_op) begin
                    s_vec <= w_g_onehot;
                    flags <= flags | w_g_onehot;
                end else begin
                    r_vec <= w_g_onehot;
                    flags <= flags & ~w_g_onehot;
                end
            end
            if (w_start_sweep) begin
                r_sweep_idx <= '0;
            end else if (w_sweep_step) begin
                r_vec       <= w_sweep_onehot;
                flags       <= flags & ~w_sweep_onehot;
                r_sweep_idx <= r_sweep_idx + 1'b1;
            end
        end
    end

`ifdef SR_CTRL_STATS_EN
    logic [7:0] r_contend_cnt;

    // Saturating count of idle cycles with both requesters eligible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_contend_cnt <= 8'h00;
        end else if ((r_state == ST_IDLE) && w_contend && (r_contend_cnt != 8'hFF)) begin
            r_contend_cnt <= r_contend_cnt + 8'h01;
        end
    end

    assign contend_cnt = r_contend_cnt;
`else
    assign contend_cnt = 8'h00;
`endif

endmodule
